// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the E stage, owning HI/LO.
// Ops latch at accept; the result is formed from the latched operands and written to HI/LO at the last busy edge.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic [WIDTH-1:0]   hi_nx, lo_nx;
  logic               commit;
  logic               accept;
  logic [2*WIDTH-1:0] result;

  logic [2:0]         op_p0;
  logic [WIDTH-1:0]   a_p0, b_p0;

  // Product of sign- or zero-extended operands; the low 2*WIDTH bits are the exact product.
  function automatic logic [2*WIDTH-1:0] mul_result(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic sgn);
    logic [2*WIDTH-1:0] ex, ey;
    ex = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ey = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return ex * ey;
  endfunction

  // Returns {remainder, quotient}; magnitudes are divided unsigned so MIN / -1 wraps to MIN with no special case.
  function automatic logic [2*WIDTH-1:0] div_result(input logic [WIDTH-1:0] n,
                                                   input logic [WIDTH-1:0] d,
                                                   input logic sgn);
    logic             neg_n, neg_d;
    logic [WIDTH-1:0] mag_n, mag_d, q, r;
    if (d == '0) return {n, {WIDTH{1'b1}}};
    neg_n = sgn & n[WIDTH-1];
    neg_d = sgn & d[WIDTH-1];
    mag_n = neg_n ? -n : n;
    mag_d = neg_d ? -d : d;
    q = mag_n / mag_d;
    r = mag_n % mag_d;
    if (neg_n ^ neg_d) q = -q;
    if (neg_n) r = -r;
    return {r, q};
  endfunction

  assign accept = start & ~flush & (state == S_IDLE) &
                  (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD});
  assign busy   = (state != S_IDLE) | accept;

  always_comb begin
    if (op_p0 == OP_DIV || op_p0 == OP_DIVU) begin
      result = div_result(a_p0, b_p0, op_p0 == OP_DIV);
    end else begin
      result = mul_result(a_p0, b_p0, op_p0 != OP_MULTU);
      if (op_p0 == OP_MADD) result = result + {hi, lo};
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    hi_nx    = hi;
    lo_nx    = lo;
    commit   = 1'b0;
    if (flush) begin
      state_nx = S_IDLE;
      count_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_MADD: begin
                state_nx = S_MUL;
                count_nx = CNT_W'(MUL_LAT - 1);
              end
              OP_DIV, OP_DIVU: begin
                state_nx = S_DIV;
                count_nx = CNT_W'(DIV_LAT - 1);
              end
              OP_MTHI: hi_nx = a;
              OP_MTLO: lo_nx = a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (count == '0) begin
            commit   = 1'b1;
            state_nx = S_IDLE;
            hi_nx    = result[2*WIDTH-1:WIDTH];
            lo_nx    = result[WIDTH-1:0];
          end else begin
            count_nx = count - 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      done  <= commit;
    end
  end

  // Stage p0: operand capture at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= op;
      a_p0  <= a;
      b_p0  <= b;
    end
  end

endmodule
